// File: rtl/fp_mult_seq_ctrl.sv
// Sequencing controller for the multi-cycle IEEE-754 single-precision multiplier:
// operand accept, 24-step shift-add mantissa multiply, exponent adjust, result hold.
module fp_mult_seq_ctrl #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int BIAS      = 127
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   result,
  output logic                           overflow,
  output logic                           underflow,
  output logic                           busy
);
  localparam int W  = EXP_WIDTH + MAN_WIDTH + 1;
  localparam int MW = MAN_WIDTH + 1;
  localparam int AW = 2 * MW;
  localparam int EW = EXP_WIDTH + 2;
  localparam int CW = $clog2(MW);
  localparam logic [EXP_WIDTH-1:0]  EMAX     = '1;
  localparam logic signed [EW-1:0]  EXP_SAT  = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0]  EXP_ZERO = '0;
  localparam logic signed [EW-1:0]  BIAS_E   = EW'(BIAS);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_NORM, S_OUT} state_t;

  state_t                 state_q;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_tem_q;
  logic [MW-1:0]          ma_q, mb_q;
  logic [AW-1:0]          acc_q;
  logic [CW-1:0]          cnt_q;
  logic                   out_valid_q, ovf_q, unf_q;
  logic [W-1:0]           result_q;

  // operand classification at accept; exponent field 0 is treated as zero
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [MAN_WIDTH-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_d;
  logic signed [EW-1:0] exp_tem_d;

  assign ea     = a[W-2 -: EXP_WIDTH];
  assign eb     = b[W-2 -: EXP_WIDTH];
  assign fa     = a[MAN_WIDTH-1:0];
  assign fb     = b[MAN_WIDTH-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);
  assign sign_d = a[W-1] ^ b[W-1];
  assign exp_tem_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;

  logic [AW-1:0]        acc_d;
  logic                 exp_inc;
  logic [MAN_WIDTH-1:0] mant_d;
  logic signed [EW-1:0] exp_value_d;

  assign acc_d       = mb_q[cnt_q] ? acc_q + (AW'(ma_q) << cnt_q) : acc_q;
  assign exp_inc     = acc_q[AW-1];
  assign mant_d      = exp_inc ? acc_q[AW-2 -: MAN_WIDTH] : acc_q[AW-3 -: MAN_WIDTH];
  assign exp_value_d = exp_tem_q + $signed({{(EW-1){1'b0}}, exp_inc});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_tem_q   <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sign_q    <= sign_d;
          exp_tem_q <= exp_tem_d;
          ma_q      <= {1'b1, fa};
          mb_q      <= {1'b1, fb};
          acc_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
          unf_q     <= 1'b0;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_q    <= QNAN;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (a_inf || b_inf) begin
            result_q    <= {sign_d, EMAX, {MAN_WIDTH{1'b0}}};
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (a_zero || b_zero) begin
            result_q    <= {sign_d, {(W-1){1'b0}}};
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            state_q <= S_MULT;
          end
        end
        S_MULT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(MW - 1)) state_q <= S_NORM;
        end
        S_NORM: begin
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
          if (exp_value_d >= EXP_SAT) begin
            result_q <= {sign_q, EMAX, {MAN_WIDTH{1'b0}}};
            ovf_q    <= 1'b1;
          end else if (exp_value_d <= EXP_ZERO) begin
            result_q <= {sign_q, {(W-1){1'b0}}};
            unf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, exp_value_d[EXP_WIDTH-1:0], mant_d};
          end
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule
